// File: rtl/icb_rr_arbiter_pkg.sv
// Shared source ids, outstanding-entry layout and
// round-robin helpers for the ICB arbiter.
package icb_rr_arbiter_pkg;

   localparam logic [1:0] SRC_WEIGHT = 2'd0;
   localparam logic [1:0] SRC_IMAP   = 2'd1;
   localparam logic [1:0] SRC_OMAP   = 2'd2;

   localparam int ENT_W = 34;

   typedef struct packed {
      logic [1:0]  src;
      logic [31:0] addr;
   } ost_ent_t;

   function automatic logic [1:0] rr_next(
      input logic [1:0] s
   );
      return (s == SRC_OMAP) ? SRC_WEIGHT : s + 2'd1;
   endfunction

   // first eligible source at or after ptr
   function automatic logic [1:0] rr_pick(
      input logic [2:0] elig,
      input logic [1:0] ptr
   );
      logic [1:0] s;
      logic [1:0] pick;
      logic       found;
      s     = ptr;
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (!found && elig[s]) begin
            pick  = s;
            found = 1'b1;
         end
         s = rr_next(s);
      end
      return pick;
   endfunction

endpackage

// File: rtl/icb_rr_arbiter_if.sv
// Source-side command/response channels, ICB master
// channels and the sticky error flag of the arbiter.
interface icb_rr_arbiter_if;

   logic        weight_req;
   logic        weight_vld;
   logic [31:0] weight_addr;
   logic        weight_rdy;
   logic [31:0] weight_rsp_addr;
   logic [31:0] weight_rsp_data;
   logic        weight_rsp_vld;
   logic        weight_rsp_rdy;

   logic        imap_req;
   logic        imap_vld;
   logic [31:0] imap_addr;
   logic        imap_rdy;
   logic [31:0] imap_rsp_addr;
   logic [31:0] imap_rsp_data;
   logic        imap_rsp_vld;
   logic        imap_rsp_rdy;

   logic        omap_req;
   logic        omap_vld;
   logic [31:0] omap_addr;
   logic [31:0] omap_data;
   logic        omap_rdy;

   logic        icb_cmd_valid;
   logic        icb_cmd_ready;
   logic [31:0] icb_cmd_addr;
   logic        icb_cmd_read;
   logic [31:0] icb_cmd_wdata;
   logic [3:0]  icb_cmd_wmask;

   logic        icb_rsp_valid;
   logic        icb_rsp_ready;
   logic        icb_rsp_err;
   logic [31:0] icb_rsp_rdata;

   logic        arb_err;

   modport slave (
      input  weight_req, weight_vld, weight_addr,
      input  weight_rsp_rdy,
      output weight_rdy, weight_rsp_addr,
      output weight_rsp_data, weight_rsp_vld,
      input  imap_req, imap_vld, imap_addr,
      input  imap_rsp_rdy,
      output imap_rdy, imap_rsp_addr,
      output imap_rsp_data, imap_rsp_vld,
      input  omap_req, omap_vld, omap_addr,
      input  omap_data,
      output omap_rdy,
      output icb_cmd_valid, icb_cmd_addr,
      output icb_cmd_read, icb_cmd_wdata,
      output icb_cmd_wmask,
      input  icb_cmd_ready,
      input  icb_rsp_valid, icb_rsp_err,
      input  icb_rsp_rdata,
      output icb_rsp_ready,
      output arb_err
   );

   modport master (
      output weight_req, weight_vld, weight_addr,
      output weight_rsp_rdy,
      input  weight_rdy, weight_rsp_addr,
      input  weight_rsp_data, weight_rsp_vld,
      output imap_req, imap_vld, imap_addr,
      output imap_rsp_rdy,
      input  imap_rdy, imap_rsp_addr,
      input  imap_rsp_data, imap_rsp_vld,
      output omap_req, omap_vld, omap_addr,
      output omap_data,
      input  omap_rdy,
      input  icb_cmd_valid, icb_cmd_addr,
      input  icb_cmd_read, icb_cmd_wdata,
      input  icb_cmd_wmask,
      output icb_cmd_ready,
      output icb_rsp_valid, icb_rsp_err,
      output icb_rsp_rdata,
      input  icb_rsp_ready,
      input  arb_err
   );

endinterface

// File: rtl/icb_rr_arbiter_ost_fifo.sv
// In-order outstanding-command FIFO: remembers who
// issued each ICB command and at which address.
module ost_fifo
   import icb_rr_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = ENT_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  logic [W-1:0]           i_din,
   input  logic                   i_pop,
   output logic [W-1:0]           o_dout,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_cnt;
   logic          w_push;
   logic          w_pop;

   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_count = r_cnt;
   assign o_dout  = r_mem[r_rp];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= i_din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/icb_rr_arbiter.sv
// Round-robin ICB arbiter for weight/imap reads and
// omap writes, with in-order response routing.
module icb_rr_arbiter
   import icb_rr_arbiter_pkg::*;
#(
   parameter int OST_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   icb_rr_arbiter_if.slave  bus
);

   localparam int CW = $clog2(OST_DEPTH) + 1;

   logic [2:0]    w_elig;
   logic [1:0]    w_gnt;
   logic          w_cmd_vld;
   logic          w_cmd_hs;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_cnt;
   ost_ent_t      w_push_ent;
   ost_ent_t      w_head;
   logic          w_rsp_hs;
   logic          w_drop;
   logic          w_err_set;

   logic [1:0]    r_ptr;
   logic [1:0]    r_lock_src;
   logic          r_lock;
   logic          r_err;

   assign w_elig = {
      bus.omap_req   & bus.omap_vld,
      bus.imap_req   & bus.imap_vld,
      bus.weight_req & bus.weight_vld
   };

   // a stalled command keeps its source
   assign w_gnt = (r_lock & w_elig[r_lock_src])
                ? r_lock_src
                : rr_pick(w_elig, r_ptr);

   assign w_cmd_vld = rst_n & (|w_elig) & ~w_full;
   assign w_cmd_hs  = w_cmd_vld & bus.icb_cmd_ready;
   assign bus.icb_cmd_valid = w_cmd_vld;

   always_comb begin
      bus.icb_cmd_addr  = '0;
      bus.icb_cmd_read  = 1'b0;
      bus.icb_cmd_wdata = '0;
      bus.icb_cmd_wmask = 4'h0;
      bus.weight_rdy    = 1'b0;
      bus.imap_rdy      = 1'b0;
      bus.omap_rdy      = 1'b0;
      if (w_cmd_vld) begin
         unique case (1'b1)
            (w_gnt == SRC_WEIGHT): begin
               bus.icb_cmd_addr = bus.weight_addr;
               bus.icb_cmd_read = 1'b1;
               bus.weight_rdy   = bus.icb_cmd_ready;
            end
            (w_gnt == SRC_IMAP): begin
               bus.icb_cmd_addr = bus.imap_addr;
               bus.icb_cmd_read = 1'b1;
               bus.imap_rdy     = bus.icb_cmd_ready;
            end
            default: begin
               bus.icb_cmd_addr  = bus.omap_addr;
               bus.icb_cmd_wdata = bus.omap_data;
               bus.icb_cmd_wmask = 4'hF;
               bus.omap_rdy      = bus.icb_cmd_ready;
            end
         endcase
      end
   end

   assign w_push_ent = {w_gnt, bus.icb_cmd_addr};

   ost_fifo #(
      .DEPTH (OST_DEPTH),
      .W     (ENT_W)
   ) u_ost (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_cmd_hs),
      .i_din   (w_push_ent),
      .i_pop   (w_rsp_hs & ~w_empty),
      .o_dout  (w_head),
      .o_count (w_cnt),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // writes and stray responses are sunk here
   always_comb begin
      bus.icb_rsp_ready   = 1'b0;
      bus.weight_rsp_vld  = 1'b0;
      bus.weight_rsp_addr = '0;
      bus.weight_rsp_data = '0;
      bus.imap_rsp_vld    = 1'b0;
      bus.imap_rsp_addr   = '0;
      bus.imap_rsp_data   = '0;
      if (rst_n) begin
         if (w_empty) begin
            bus.icb_rsp_ready = 1'b1;
         end else begin
            unique case (1'b1)
               (w_head.src == SRC_WEIGHT): begin
                  bus.weight_rsp_vld  = bus.icb_rsp_valid;
                  bus.weight_rsp_addr = w_head.addr;
                  bus.weight_rsp_data = bus.icb_rsp_rdata;
                  bus.icb_rsp_ready   = bus.weight_rsp_rdy;
               end
               (w_head.src == SRC_IMAP): begin
                  bus.imap_rsp_vld  = bus.icb_rsp_valid;
                  bus.imap_rsp_addr = w_head.addr;
                  bus.imap_rsp_data = bus.icb_rsp_rdata;
                  bus.icb_rsp_ready = bus.imap_rsp_rdy;
               end
               default: bus.icb_rsp_ready = 1'b1;
            endcase
         end
      end
   end

   assign w_rsp_hs  = bus.icb_rsp_valid & bus.icb_rsp_ready;
   assign w_drop    = bus.icb_rsp_valid & (w_cnt == '0);
   assign w_err_set = w_drop | (w_rsp_hs & bus.icb_rsp_err);
   assign bus.arb_err = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr      <= SRC_WEIGHT;
         r_lock     <= 1'b0;
         r_lock_src <= SRC_WEIGHT;
         r_err      <= 1'b0;
      end else begin
         if (w_cmd_hs) r_ptr <= rr_next(w_gnt);
         r_lock     <= w_cmd_vld & ~bus.icb_cmd_ready;
         r_lock_src <= w_gnt;
         r_err      <= r_err | w_err_set;
      end
   end

endmodule

// File: tb/tb_icb_rr_arbiter.sv
// Bench for icb_rr_arbiter: directed scenarios plus
// random traffic against a queue-based reference model.
module tb_icb_rr_arbiter;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   icb_rr_arbiter_if bus();

   icb_rr_arbiter #(.OST_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int          src;
      logic [31:0] addr;
   } ent_t;

   ent_t        q[$];
   int          m_ptr;
   int          m_lock;
   bit          m_err;
   int          n_tests;
   int          n_fail;

   bit          s_cv;
   bit          s_hs;
   bit          s_pop;
   bit          s_errset;
   int          s_g;
   logic [31:0] s_addr;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.weight_req     = 0;
      bus.weight_vld     = 0;
      bus.weight_addr    = 0;
      bus.weight_rsp_rdy = 0;
      bus.imap_req       = 0;
      bus.imap_vld       = 0;
      bus.imap_addr      = 0;
      bus.imap_rsp_rdy   = 0;
      bus.omap_req       = 0;
      bus.omap_vld       = 0;
      bus.omap_addr      = 0;
      bus.omap_data      = 0;
      bus.icb_cmd_ready  = 0;
      bus.icb_rsp_valid  = 0;
      bus.icb_rsp_err    = 0;
      bus.icb_rsp_rdata  = 0;
   endtask

   task automatic set_src(input int s, input bit on,
                          input logic [31:0] a);
      case (s)
         0: begin
            bus.weight_req = on; bus.weight_vld = on;
            bus.weight_addr = a;
         end
         1: begin
            bus.imap_req = on; bus.imap_vld = on;
            bus.imap_addr = a;
         end
         default: begin
            bus.omap_req = on; bus.omap_vld = on;
            bus.omap_addr = a;
         end
      endcase
   endtask

   // compare every output with the model at negedge
   task automatic samp();
      bit          e[3];
      int          g;
      bit          cv;
      logic [31:0] ea;
      logic [2:0]  erdy;
      logic [1:0]  ev;
      bit          er;
      @(negedge clk);
      s_cv = 0; s_hs = 0; s_pop = 0; s_errset = 0;
      if (!rst_n) begin
         check("rst_cmd_valid", bus.icb_cmd_valid, 0);
         check("rst_rsp_ready", bus.icb_rsp_ready, 0);
         check("rst_rdy", {bus.weight_rdy, bus.imap_rdy,
               bus.omap_rdy}, 0);
         check("rst_rsp_vld", {bus.weight_rsp_vld,
               bus.imap_rsp_vld}, 0);
         check("rst_cmd_bus", {bus.icb_cmd_addr,
               bus.icb_cmd_wmask}, 0);
         check("rst_cmd_wdata", bus.icb_cmd_wdata, 0);
         check("rst_w_rsp", {bus.weight_rsp_addr,
               bus.weight_rsp_data}, 0);
         check("rst_i_rsp", {bus.imap_rsp_addr,
               bus.imap_rsp_data}, 0);
         check("rst_arb_err", bus.arb_err, 0);
         return;
      end
      e[0] = bus.weight_req && bus.weight_vld;
      e[1] = bus.imap_req && bus.imap_vld;
      e[2] = bus.omap_req && bus.omap_vld;
      g = -1;
      if (m_lock >= 0 && e[m_lock]) g = m_lock;
      else
         for (int k = 0; k < 3; k++)
            if (g < 0 && e[(m_ptr + k) % 3])
               g = (m_ptr + k) % 3;
      cv = (g >= 0) && (q.size() < DEPTH);
      check("cmd_valid", bus.icb_cmd_valid, cv);
      erdy = 0;
      ea   = 0;
      if (cv) begin
         case (g)
            0:       ea = bus.weight_addr;
            1:       ea = bus.imap_addr;
            default: ea = bus.omap_addr;
         endcase
         check("cmd_addr", bus.icb_cmd_addr, ea);
         check("cmd_rw", {bus.icb_cmd_read,
               bus.icb_cmd_wmask},
               (g == 2) ? 5'h0F : 5'h10);
         if (g == 2)
            check("cmd_wdata", bus.icb_cmd_wdata,
                  bus.omap_data);
         if (bus.icb_cmd_ready) erdy[2 - g] = 1'b1;
      end
      check("src_rdy", {bus.weight_rdy, bus.imap_rdy,
            bus.omap_rdy}, erdy);
      ev = 0;
      er = 1;
      if (q.size() > 0) begin
         case (q[0].src)
            0: begin
               ev[1] = bus.icb_rsp_valid;
               er = bus.weight_rsp_rdy;
            end
            1: begin
               ev[0] = bus.icb_rsp_valid;
               er = bus.imap_rsp_rdy;
            end
            default: er = 1;
         endcase
      end
      check("rsp_ready", bus.icb_rsp_ready, er);
      check("rsp_vld", {bus.weight_rsp_vld,
            bus.imap_rsp_vld}, ev);
      if (ev[1])
         check("w_rsp", {bus.weight_rsp_addr,
               bus.weight_rsp_data},
               {q[0].addr, bus.icb_rsp_rdata});
      if (ev[0])
         check("i_rsp", {bus.imap_rsp_addr,
               bus.imap_rsp_data},
               {q[0].addr, bus.icb_rsp_rdata});
      check("arb_err", bus.arb_err, m_err);
      s_g = g;
      s_cv = cv;
      s_hs = cv && bus.icb_cmd_ready;
      s_addr = ea;
      s_pop = bus.icb_rsp_valid && er && q.size() > 0;
      s_errset = bus.icb_rsp_valid &&
                 (q.size() == 0 || (er && bus.icb_rsp_err));
   endtask

   task automatic adv();
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
         m_ptr = 0; m_lock = -1; m_err = 0;
      end else begin
         if (s_pop) void'(q.pop_front());
         if (s_hs) begin
            q.push_back('{s_g, s_addr});
            m_ptr = (s_g + 1) % 3;
         end
         m_lock = (s_cv && !s_hs) ? s_g : -1;
         if (s_errset) m_err = 1;
      end
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      samp(); adv();
      samp(); adv();
      rst_n = 1;
   endtask

   task automatic drain();
      set_src(0, 0, 0); set_src(1, 0, 0); set_src(2, 0, 0);
      bus.icb_rsp_valid  = 1;
      bus.icb_rsp_err    = 0;
      bus.weight_rsp_rdy = 1;
      bus.imap_rsp_rdy   = 1;
      for (int i = 0; i < DEPTH + 4 && q.size() > 0; i++) begin
         bus.icb_rsp_rdata = $urandom;
         samp(); adv();
      end
      bus.icb_rsp_valid = 0;
   endtask

   task automatic rnd_inputs();
      for (int s = 0; s < 3; s++) begin
         if (s != m_lock) begin
            set_src(s, ($urandom % 3) != 0, $urandom);
            if (s == 0) bus.weight_vld = ($urandom % 4) != 0;
            if (s == 1) bus.imap_vld   = ($urandom % 4) != 0;
            if (s == 2) begin
               bus.omap_vld  = ($urandom % 4) != 0;
               bus.omap_data = $urandom;
            end
         end
      end
      bus.icb_cmd_ready  = ($urandom % 4) != 0;
      bus.icb_rsp_valid  = (q.size() > 0)
                         ? ($urandom % 2) == 0
                         : ($urandom % 64) == 0;
      bus.icb_rsp_err    = ($urandom % 32) == 0;
      bus.icb_rsp_rdata  = $urandom;
      bus.weight_rsp_rdy = ($urandom % 4) != 0;
      bus.imap_rsp_rdy   = ($urandom % 4) != 0;
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      m_ptr = 0; m_lock = -1; m_err = 0;
      idle();
      rst_n = 0;
      // reset with every source requesting
      set_src(0, 1, 32'h1); set_src(1, 1, 32'h2);
      set_src(2, 1, 32'h3);
      bus.icb_cmd_ready = 1; bus.icb_rsp_valid = 1;
      samp();
      check("rst_valid_hi_in", bus.icb_cmd_valid, 0);
      adv();
      do_reset();

      // round-robin with all three eligible
      set_src(0, 1, 32'h10); set_src(1, 1, 32'h20);
      set_src(2, 1, 32'h30);
      bus.omap_data = 32'h55;
      bus.icb_cmd_ready = 1;
      bus.weight_rsp_rdy = 1; bus.imap_rsp_rdy = 1;
      for (int k = 0; k < 6; k++) begin
         bus.icb_rsp_valid = (k > 0);
         samp();
         check("rr_read", bus.icb_cmd_read, (k % 3) != 2);
         check("rr_mask", bus.icb_cmd_wmask,
               (k % 3 == 2) ? 4'hF : 4'h0);
         check("rr_addr", bus.icb_cmd_addr,
               32'h10 * (k % 3 + 1));
         adv();
      end
      drain();

      // lock while stalled, pointer already at imap
      do_reset();
      set_src(0, 1, 32'h40);
      bus.icb_cmd_ready = 1;
      samp(); adv();
      set_src(0, 1, 32'h44);
      bus.icb_cmd_ready = 0;
      for (int k = 0; k < 3; k++) begin
         samp();
         check("lock_w", bus.icb_cmd_addr, 32'h44);
         adv();
      end
      set_src(1, 1, 32'h80);
      samp();
      check("lock_hold", bus.icb_cmd_addr, 32'h44);
      adv();
      bus.icb_cmd_ready = 1;
      samp();
      check("lock_hs", {bus.weight_rdy, bus.imap_rdy}, 2'b10);
      adv();
      set_src(0, 0, 0);
      samp();
      check("lock_next", bus.icb_cmd_addr, 32'h80);
      adv();
      drain();

      // outstanding limit
      do_reset();
      set_src(0, 1, 32'h300);
      bus.icb_cmd_ready = 1;
      for (int k = 0; k < 6; k++) begin
         samp();
         check("ost_full", bus.icb_cmd_valid, k < DEPTH);
         adv();
      end
      bus.icb_rsp_valid = 1; bus.weight_rsp_rdy = 1;
      samp();
      check("full_pop_same", bus.icb_cmd_valid, 0);
      adv();
      bus.icb_rsp_valid = 0;
      samp();
      check("full_after_pop", bus.icb_cmd_valid, 1);
      adv();
      drain();

      // response routing and backpressure
      do_reset();
      set_src(0, 1, 32'h100);
      bus.icb_cmd_ready = 1;
      samp(); adv();
      set_src(0, 0, 0); set_src(1, 1, 32'h200);
      samp(); adv();
      set_src(1, 0, 0);
      bus.icb_rsp_valid = 1; bus.icb_rsp_rdata = 32'hAAAA;
      bus.weight_rsp_rdy = 1; bus.imap_rsp_rdy = 0;
      samp();
      check("w_route", {bus.weight_rsp_vld,
            bus.weight_rsp_addr, bus.weight_rsp_data},
            {1'b1, 32'h100, 32'hAAAA});
      adv();
      bus.icb_rsp_rdata = 32'hBBBB;
      samp();
      check("i_route", {bus.imap_rsp_vld,
            bus.imap_rsp_addr}, {1'b1, 32'h200});
      check("i_stall", bus.icb_rsp_ready, 0);
      adv();
      bus.imap_rsp_rdy = 1;
      samp();
      check("i_data", {bus.icb_rsp_ready,
            bus.imap_rsp_data}, {1'b1, 32'hBBBB});
      adv();
      bus.icb_rsp_valid = 0;
      samp();
      check("no_err", bus.arb_err, 0);
      adv();

      // stray response sets sticky error
      bus.icb_rsp_valid = 1;
      samp();
      check("err_pre", bus.arb_err, 0);
      adv();
      bus.icb_rsp_valid = 0;
      for (int k = 0; k < 3; k++) begin
         samp();
         check("err_sticky", bus.arb_err, 1);
         adv();
      end
      rst_n = 0;
      samp();
      check("err_clr", bus.arb_err, 0);
      adv();
      rst_n = 1;

      // error response on a read
      set_src(0, 1, 32'h10);
      bus.icb_cmd_ready = 1;
      samp(); adv();
      set_src(0, 0, 0);
      bus.icb_rsp_valid = 1; bus.icb_rsp_err = 1;
      bus.weight_rsp_rdy = 1;
      samp();
      check("err_fwd", bus.weight_rsp_vld, 1);
      adv();
      bus.icb_rsp_valid = 0; bus.icb_rsp_err = 0;
      samp();
      check("rsp_err_set", bus.arb_err, 1);
      adv();

      // reset with three commands outstanding
      do_reset();
      set_src(0, 1, 32'h500);
      bus.icb_cmd_ready = 1;
      for (int k = 0; k < 3; k++) begin
         samp(); adv();
      end
      set_src(0, 0, 0);
      rst_n = 0;
      samp(); adv();
      rst_n = 1;
      bus.icb_rsp_valid = 1; bus.weight_rsp_rdy = 1;
      samp();
      check("post_rst_no_fwd", {bus.weight_rsp_vld,
            bus.icb_rsp_ready}, 2'b01);
      adv();
      bus.icb_rsp_valid = 0;
      samp();
      check("post_rst_err", bus.arb_err, 1);
      adv();

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         if (c % 500 == 0) do_reset();
         rnd_inputs();
         samp(); adv();
      end

      $display("[TB] %0d tests run, %0d failed",
               n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/icb_rr_arbiter.md
ICB_RR_ARBITER -- requirements
Module: icb_rr_arbiter

Interface
REQ-001 Parameter OST_DEPTH, default 4, SHALL set the maximum number of outstanding ICB commands (power of two, 2..8).
REQ-002 Port clk  input  1  single clock; all flops on its rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Ports weight_req/weight_vld  input  1 each, weight_addr  input  32, weight_rdy  output  1: weight read-command channel.
REQ-005 Ports weight_rsp_addr  output  32, weight_rsp_data  output  32, weight_rsp_vld  output  1, weight_rsp_rdy  input  1: weight read-response channel.
REQ-006 Ports imap_req/imap_vld  input  1 each, imap_addr  input  32, imap_rdy  output  1, imap_rsp_addr/imap_rsp_data  output  32 each, imap_rsp_vld  output  1, imap_rsp_rdy  input  1: imap read channels.
REQ-007 Ports omap_req/omap_vld  input  1 each, omap_addr/omap_data  input  32 each, omap_rdy  output  1: omap write-command channel.
REQ-008 Ports icb_cmd_valid  output  1, icb_cmd_ready  input  1, icb_cmd_addr  output  32, icb_cmd_read  output  1, icb_cmd_wdata  output  32, icb_cmd_wmask  output  4: ICB command channel.
REQ-009 Ports icb_rsp_valid  input  1, icb_rsp_ready  output  1, icb_rsp_err  input  1, icb_rsp_rdata  input  32: ICB response channel.
REQ-010 Port arb_err  output  1: sticky error flag.

Function
REQ-011 A source SHALL be eligible when its req and vld are both high.
REQ-012 Grant SHALL be round-robin over order weight(0), imap(1), omap(2); search starts at pointer; pointer resets to 0 and moves to (granted+1) mod 3 on each cmd handshake.
REQ-013 While icb_cmd_valid=1 and icb_cmd_ready=0, grant SHALL stay locked to the current source; no re-arbitration mid-handshake.
REQ-014 icb_cmd_valid SHALL equal (any eligible) AND (outstanding FIFO not full); combinational, zero-cycle latency.
REQ-015 icb_cmd_addr/wdata SHALL mux from granted source; icb_cmd_read=1 and wmask=4'h0 for weight/imap; read=0, wmask=4'hF, wdata=omap_data for omap.
REQ-016 Granted source rdy SHALL equal icb_cmd_ready AND icb_cmd_valid; non-granted rdy SHALL be 0.
REQ-017 On cmd handshake, {source id (2b), addr (32b)} SHALL be pushed into an in-order outstanding FIFO of OST_DEPTH entries.
REQ-018 When FIFO full, no command SHALL issue, even if a response pops the same cycle (push decision uses registered count only).
REQ-019 Response routing SHALL use FIFO head: head=weight -> weight_rsp_vld=icb_rsp_valid, icb_rsp_ready=weight_rsp_rdy; same for imap; head=omap -> icb_rsp_ready=1, no forward.
REQ-020 rsp_data SHALL equal icb_rsp_rdata and rsp_addr SHALL equal stored head address; non-head rsp_vld SHALL be 0.
REQ-021 FIFO pop SHALL occur on icb_rsp_valid AND icb_rsp_ready; simultaneous push and pop SHALL keep count unchanged.
REQ-022 icb_rsp_valid with empty FIFO SHALL be dropped with icb_rsp_ready=1 and SHALL set arb_err.
REQ-023 Handshaked response with icb_rsp_err=1 SHALL set arb_err and still be forwarded/popped normally.
REQ-024 arb_err SHALL stay set until reset.

Reset
REQ-025 rst_n low SHALL immediately clear FIFO pointers and count, RR pointer to 0, arb_err to 0.
REQ-026 During reset all outputs SHALL be 0: icb_cmd_valid, icb_rsp_ready, all rdy/vld, addr/data/wmask.
REQ-027 Reset mid-operation SHALL discard outstanding entries; no response is forwarded after release until a new command issues.

Structure
REQ-028 Shared package SHALL hold source-id constants (SRC_WEIGHT=0, SRC_IMAP=1, SRC_OMAP=2) and the 34-bit FIFO entry width.
REQ-029 Outstanding FIFO SHALL be one sub-module, ost_fifo (sync FIFO, count output, full/empty flags).

Verification
REQ-030 All three eligible every cycle, cmd_ready=1 -> grant order 0,1,2,0,1,2; cmd_read 1,1,0 repeating; omap wmask=4'hF.
REQ-031 weight eligible, cmd_ready=0 for 3 cycles then imap also eligible -> grant stays weight until handshake, imap next.
REQ-032 Five reads with rsp_valid=0, OST_DEPTH=4 -> four handshakes, fifth held with icb_cmd_valid=0 until one response pops.
REQ-033 Issue weight@0x100 then imap@0x200, responses 0xAAAA, 0xBBBB -> weight gets (0x100,0xAAAA), imap gets (0x200,0xBBBB); imap_rsp_rdy=0 stalls icb_rsp_ready.
REQ-034 rsp_valid with empty FIFO, or rsp_err=1 on a read -> arb_err=1 next cycle, stays 1; rst_n low clears it.
REQ-035 Reset asserted with 3 outstanding -> count=0, outputs 0; post-release response without command sets arb_err.
